// File: rtl/collision_search_ctrl_pkg.sv
// Shared types and defaults for the collision search sequencer.
package collision_search_ctrl_pkg;

  localparam int unsigned TARGET_W               = 5;
  localparam int unsigned NONCE_W_DEFAULT        = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_HASH = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/collision_search_ctrl_watchdog.sv
// search_watchdog: loadable down-counter whose expiry flag marks a hash that never returned.
module search_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Loaded one below the limit so expiry lands in the last permitted wait cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/collision_search_ctrl.sv
// Nonce search sequencer between the collision checker and the SHA-1 core.
// Optional hash watchdog compiled in with SEARCH_WATCHDOG_EN.
module collision_search_ctrl
  import collision_search_ctrl_pkg::*;
#(
  parameter int unsigned NONCE_W        = NONCE_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic [TARGET_W-1:0] iTarget,
  input  logic [NONCE_W-1:0]  iBaseNonce,
  input  logic [NONCE_W-1:0]  iMaxTries,
  input  logic                iShaReady,
  input  logic                iCollision,
  output logic                oShaStart,
  output logic [NONCE_W-1:0]  oNonce,
  output logic [TARGET_W-1:0] oTarget,
  output logic                oBusy,
  output logic                oDone,
  output logic                oFound,
  output logic [NONCE_W-1:0]  oFoundNonce,
  output logic [NONCE_W-1:0]  oAttempts,
  output logic                oError
);

  state_t             state;
  logic [NONCE_W-1:0] max_tries;
  logic               wd_expired;

`ifdef SEARCH_WATCHDOG_EN
  logic wd_load;
  logic wd_run;

  assign wd_load = (state == ST_LAUNCH);
  assign wd_run  = (state == ST_WAIT_HASH);

  search_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (iClk),
    .rst_n  (iRstN),
    .load   (wd_load),
    .en     (wd_run),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  assign oBusy = (state != ST_IDLE);

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state       <= ST_IDLE;
      max_tries   <= '0;
      oShaStart   <= 1'b0;
      oNonce      <= '0;
      oTarget     <= '0;
      oDone       <= 1'b0;
      oFound      <= 1'b0;
      oFoundNonce <= '0;
      oAttempts   <= '0;
      oError      <= 1'b0;
    end else begin
      oShaStart <= 1'b0;
      oDone     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (iStart) begin
            oTarget   <= iTarget;
            max_tries <= iMaxTries;
            oNonce    <= iBaseNonce;
            oFound    <= 1'b0;
            oAttempts <= '0;
            oError    <= 1'b0;
            oShaStart <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (iAbort) begin
            oDone <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_WAIT_HASH;
          end
        end
        // Abort outranks a coincident ready; a ready outranks a coincident timeout.
        ST_WAIT_HASH: begin
          if (iAbort) begin
            oDone <= 1'b1;
            state <= ST_DONE;
          end else if (iShaReady) begin
            if (~&oAttempts) oAttempts <= oAttempts + NONCE_W'(1);
            state <= ST_SETTLE;
          end else if (wd_expired) begin
            oError <= 1'b1;
            oDone  <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_SETTLE: begin
          if (iAbort) begin
            oDone <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (iCollision) begin
            oFound      <= 1'b1;
            oFoundNonce <= oNonce;
            oDone       <= 1'b1;
            state       <= ST_DONE;
          end else if (iAbort || ((max_tries != '0) && (oAttempts == max_tries))) begin
            oDone <= 1'b1;
            state <= ST_DONE;
          end else begin
            oNonce    <= oNonce + NONCE_W'(1);
            oShaStart <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_search_ctrl.sv
// Directed bench for collision_search_ctrl with a closed-form timeline model of each search.
module tb_collision_search_ctrl;

  localparam int LAT = 5;
  localparam int P   = LAT + 3;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iStart;
  logic        iAbort;
  logic [4:0]  iTarget;
  logic [31:0] iBaseNonce;
  logic [31:0] iMaxTries;
  logic        iShaReady;
  logic        iCollision;
  logic        oShaStart;
  logic [31:0] oNonce;
  logic [4:0]  oTarget;
  logic        oBusy;
  logic        oDone;
  logic        oFound;
  logic [31:0] oFoundNonce;
  logic [31:0] oAttempts;
  logic        oError;

  always #5 iClk = ~iClk;

  collision_search_ctrl #(
    .NONCE_W       (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iStart     (iStart),
    .iAbort     (iAbort),
    .iTarget    (iTarget),
    .iBaseNonce (iBaseNonce),
    .iMaxTries  (iMaxTries),
    .iShaReady  (iShaReady),
    .iCollision (iCollision),
    .oShaStart  (oShaStart),
    .oNonce     (oNonce),
    .oTarget    (oTarget),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oFound     (oFound),
    .oFoundNonce(oFoundNonce),
    .oAttempts  (oAttempts),
    .oError     (oError)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scenario description and its derived outcome
  logic [31:0] m_base, m_max, m_prev_fn, m_nonce_f, m_att_f, m_fn_f;
  logic [4:0]  m_target;
  int          m_hit, m_abort, m_done_t;
  logic        m_found_f;

  int run = 0;
  int t = 0;
  int n_launch = 0;
  int done_seen = 0;

  // Launch of nonce i happens in cycle 1+i*P; each nonce occupies P cycles.
  task automatic plan(input logic [31:0] base, input logic [31:0] max_tries, input int hit_idx,
                      input int abort_at, input logic [4:0] target);
    int  k, done_nat, i, ph;
    bit  hit;
    m_base = base; m_max = max_tries; m_hit = hit_idx; m_abort = abort_at; m_target = target;
    hit = (hit_idx >= 0) && ((max_tries == 0) || (hit_idx < int'(max_tries)));
    if (hit) k = hit_idx;
    else if (max_tries != 0) k = int'(max_tries) - 1;
    else k = 100000;
    done_nat  = (k + 1) * P + 1;
    m_done_t  = done_nat;
    m_found_f = hit;
    m_nonce_f = base + 32'(k);
    m_att_f   = 32'(k + 1);
    if (abort_at > 0 && abort_at < done_nat) begin
      i  = (abort_at - 1) / P;
      ph = (abort_at - 1) % P;
      if (!(ph == LAT + 2 && i == hit_idx)) begin
        m_done_t  = abort_at + 1;
        m_found_f = 1'b0;
        m_nonce_f = base + 32'(i);
        m_att_f   = 32'(i) + ((ph >= LAT + 1) ? 32'd1 : 32'd0);
      end
    end
    m_fn_f = m_found_f ? m_nonce_f : m_prev_fn;
  endtask

  always @(negedge iClk) begin : cmp
    int          i, ph;
    logic [31:0] en, ea, efn;
    logic        es, eb, ed, ef;
    if (run != 0 && t >= 1) begin
      if (t < m_done_t) begin
        i   = (t - 1) / P;
        ph  = (t - 1) % P;
        es  = (ph == 0);
        en  = m_base + 32'(i);
        ea  = 32'(i) + ((ph >= LAT + 1) ? 32'd1 : 32'd0);
        eb  = 1'b1;
        ed  = 1'b0;
        ef  = 1'b0;
        efn = m_prev_fn;
      end else begin
        es  = 1'b0;
        en  = m_nonce_f;
        ea  = m_att_f;
        eb  = (t == m_done_t);
        ed  = (t == m_done_t);
        ef  = m_found_f;
        efn = m_fn_f;
      end
      check("sha_start", 32'(oShaStart), 32'(es));
      check("nonce", oNonce, en);
      check("target", 32'(oTarget), 32'(m_target));
      check("busy", 32'(oBusy), 32'(eb));
      check("done", 32'(oDone), 32'(ed));
      check("found", 32'(oFound), 32'(ef));
      check("found_nonce", oFoundNonce, efn);
      check("attempts", oAttempts, ea);
      check("error", 32'(oError), 32'd0);
      if (oShaStart) n_launch++;
      if (oDone) done_seen = t;
    end
  end

  // The SHA-1 responder answers each launch LAT cycles later; the checker result follows a cycle after.
  task automatic run_search(input int glitch_at);
    int len, i_end, i, ph;
    len   = m_done_t + 4;
    i_end = (m_done_t - 2) / P;
    n_launch = 0; done_seen = 0;
    iTarget = m_target; iBaseNonce = m_base; iMaxTries = m_max;
    iCollision = 1'b0; iShaReady = 1'b0; iAbort = 1'b0;
    iStart = 1'b1;
    run = 1;
    for (int c = 1; c <= len; c++) begin
      @(posedge iClk);
      t = c;
      @(negedge iClk);
      i  = (c - 1) / P;
      ph = (c - 1) % P;
      iStart    = (c == glitch_at);
      iShaReady = (ph == LAT) && (i <= i_end);
      if (ph == LAT + 1 && i <= i_end) iCollision = (i == m_hit);
      iAbort    = (c == m_abort);
    end
    @(posedge iClk);
    run = 0; t = 0;
    iStart = 1'b0; iShaReady = 1'b0; iAbort = 1'b0;
    @(negedge iClk);
    m_prev_fn = m_fn_f;
  endtask

  initial begin
    iRstN = 1'b0; iStart = 1'b0; iAbort = 1'b0; iTarget = '0; iBaseNonce = '0;
    iMaxTries = '0; iShaReady = 1'b0; iCollision = 1'b0;
    m_prev_fn = '0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check("rst_sha_start", 32'(oShaStart), 0);
    check("rst_nonce", oNonce, 0);
    check("rst_target", 32'(oTarget), 0);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_done", 32'(oDone), 0);
    check("rst_found", 32'(oFound), 0);
    check("rst_found_nonce", oFoundNonce, 0);
    check("rst_attempts", oAttempts, 0);
    check("rst_error", 32'(oError), 0);
    iRstN = 1'b1;
    @(negedge iClk);

    // Hit on the third nonce
    plan(32'h10, 32'd0, 2, 0, 5'd7);
    run_search(0);
    check("hit_launches", 32'(n_launch), 3);
    check("hit_done_cycle", 32'(done_seen), 25);
    check("hit_found", 32'(oFound), 1);
    check("hit_found_nonce", oFoundNonce, 32'h12);
    check("hit_attempts", oAttempts, 3);

    // Attempt limit, with a stray start mid-search
    plan(32'h100, 32'd4, -1, 0, 5'd31);
    run_search(10);
    check("lim_launches", 32'(n_launch), 4);
    check("lim_done_cycle", 32'(done_seen), 33);
    check("lim_found", 32'(oFound), 0);
    check("lim_attempts", oAttempts, 4);
    check("lim_nonce", oNonce, 32'h103);
    check("lim_found_nonce_held", oFoundNonce, 32'h12);

    // Nonce wrap
    plan(32'hFFFF_FFFF, 32'd0, 1, 0, 5'd0);
    run_search(0);
    check("wrap_found_nonce", oFoundNonce, 32'h0);
    check("wrap_attempts", oAttempts, 2);
    check("wrap_done_cycle", 32'(done_seen), 17);

    // Abort while waiting on the hash
    plan(32'h40, 32'd0, -1, 11, 5'd2);
    run_search(0);
    check("abort_done_cycle", 32'(done_seen), 12);
    check("abort_found", 32'(oFound), 0);
    check("abort_attempts", oAttempts, 1);

    // Abort coinciding with a hit in CHECK
    plan(32'h50, 32'd0, 0, 8, 5'd9);
    run_search(0);
    check("abort_hit_done_cycle", 32'(done_seen), 9);
    check("abort_hit_found", 32'(oFound), 1);
    check("abort_hit_found_nonce", oFoundNonce, 32'h50);

    // Reset during WAIT_HASH
    iTarget = 5'd3; iBaseNonce = 32'h60; iMaxTries = 32'd0; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    @(negedge iClk);
    check("pre_rst_busy", 32'(oBusy), 1);
    iRstN = 1'b0;
    @(negedge iClk);
    iRstN = 1'b1;
    check("mid_rst_busy", 32'(oBusy), 0);
    check("mid_rst_nonce", oNonce, 0);
    check("mid_rst_target", 32'(oTarget), 0);
    check("mid_rst_found_nonce", oFoundNonce, 0);
    check("mid_rst_attempts", oAttempts, 0);
    check("mid_rst_sha_start", 32'(oShaStart), 0);
    check("mid_rst_found", 32'(oFound), 0);
    check("mid_rst_error", 32'(oError), 0);
    for (int c = 0; c < 10; c++) begin
      check("mid_rst_done", 32'(oDone), 0);
      @(negedge iClk);
    end
    m_prev_fn = '0;
    plan(32'h77, 32'd0, 0, 0, 5'd1);
    run_search(0);
    check("restart_found_nonce", oFoundNonce, 32'h77);
    check("restart_attempts", oAttempts, 1);
    check("restart_done_cycle", 32'(done_seen), 9);

`ifdef SEARCH_WATCHDOG_EN
    begin
      int wd_done;
      wd_done = 0;
      iTarget = 5'd4; iBaseNonce = 32'h90; iMaxTries = 32'd0;
      iShaReady = 1'b0; iCollision = 1'b0; iStart = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge iClk);
        iStart = 1'b0;
        if (oDone && wd_done == 0) begin
          wd_done = c;
          check("wd_error", 32'(oError), 1);
          check("wd_found", 32'(oFound), 0);
        end
      end
      check("wd_done_cycle", 32'(wd_done), 18);
      check("wd_error_sticky", 32'(oError), 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
